// File: rtl/macguffin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_pkg
// Brief    : Shared widths and session state type for the MacGuffin slice.
// Revision : 1.0 - initial release
// ============================================================================
package macguffin_pkg;

    localparam int KEY_W    = 128;
    localparam int BLK_W    = 64;
    localparam int RK_W     = 48;
    localparam int N_ROUNDS = 32;

    typedef enum logic [2:0] {
        NOKEY   = 3'd0,
        KS_RST  = 3'd1,
        KS_WAIT = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4
    } sess_state_t;

endpackage
`default_nettype wire

// File: rtl/macguffin_inflight_cnt.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_inflight_cnt
// Brief    : Up/down saturating count of blocks held inside the cipher core.
// Revision : 1.0 - initial release
// ============================================================================
module macguffin_inflight_cnt #(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !dec && !full) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && !zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);
    assign full = (r_count == CNT_W'(MAX_INFLIGHT));

    // An output with nothing in flight means the core emitted a block it never received.
    a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(dec && zero));

endmodule
`default_nettype wire

// File: rtl/macguffin_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_session_ctrl
// Brief    : Sequences key_setup and block encryption for one user session.
// Revision : 1.0 - initial release
// ============================================================================
module macguffin_session_ctrl
    import macguffin_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 4,
    parameter int KS_RST_CYC   = 2,
    parameter int KS_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  s_key_tdata,
    input  logic              s_key_tvalid,
    output logic              s_key_tready,
    input  logic [BLK_W-1:0]  s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [BLK_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [BLK_W-1:0]  core_s_tdata,
    output logic              core_s_tvalid,
    input  logic              core_s_tready,
    input  logic [BLK_W-1:0]  core_m_tdata,
    input  logic              core_m_tvalid,
    output logic              core_m_tready,
    output logic [KEY_W-1:0]  ks_key,
    output logic              ks_rst,
    input  logic              ks_key_ready,
    output logic              busy,
    output logic              err,
    output logic [31:0]       block_count
);

    localparam int TMR_W = $clog2(KS_TIMEOUT + KS_RST_CYC + 1);

    localparam logic [2:0] ST_NOKEY   = NOKEY;
    localparam logic [2:0] ST_KS_RST  = KS_RST;
    localparam logic [2:0] ST_KS_WAIT = KS_WAIT;
    localparam logic [2:0] ST_RUN     = RUN;
    localparam logic [2:0] ST_DRAIN   = DRAIN;

    logic [2:0]       r_state;
    logic [KEY_W-1:0] r_ks_key;
    logic [KEY_W-1:0] r_key_pend;
    logic [TMR_W-1:0] r_tmr;
    logic             r_err;
    logic [31:0]      r_block_count;

    logic w_zero;
    logic w_full;
    logic w_gate;
    logic w_key_hs;
    logic w_in_hs;
    logic w_out_hs;

    assign w_gate   = (r_state == ST_RUN) && !w_full;
    assign w_key_hs = s_key_tvalid && s_key_tready;
    assign w_in_hs  = core_s_tvalid && core_s_tready;
    assign w_out_hs = core_m_tvalid && m_axis_tready;

    assign s_key_tready  = !rst && ((r_state == ST_NOKEY) || (r_state == ST_RUN));
    assign ks_rst        = rst || (r_state == ST_NOKEY) || (r_state == ST_KS_RST);
    assign busy          = rst || (r_state != ST_RUN);
    assign ks_key        = r_ks_key;
    assign err           = r_err;
    assign block_count   = r_block_count;

    assign core_s_tdata  = s_axis_tdata;
    assign core_s_tvalid = s_axis_tvalid && w_gate;
    assign s_axis_tready = core_s_tready && w_gate;

    // Output side is never gated so a drain always completes.
    assign m_axis_tdata  = core_m_tdata;
    assign m_axis_tvalid = core_m_tvalid;
    assign core_m_tready = m_axis_tready;

    macguffin_inflight_cnt #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_in_hs),
        .dec  (w_out_hs),
        .zero (w_zero),
        .full (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_NOKEY;
            r_ks_key      <= '0;
            r_key_pend    <= '0;
            r_tmr         <= '0;
            r_err         <= 1'b0;
            r_block_count <= '0;
        end else begin
            if (w_out_hs) begin
                r_block_count <= r_block_count + 32'd1;
            end
            case (r_state)
                ST_NOKEY: begin
                    if (w_key_hs) begin
                        r_ks_key <= s_key_tdata;
                        r_tmr    <= '0;
                        r_state  <= ST_KS_RST;
                    end
                end
                ST_KS_RST: begin
                    r_block_count <= '0;
                    if (r_tmr == TMR_W'(KS_RST_CYC - 1)) begin
                        r_tmr   <= '0;
                        r_state <= ST_KS_WAIT;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                ST_KS_WAIT: begin
                    // ks_key_ready is only trusted here, after the schedule was restarted.
                    if (ks_key_ready) begin
                        r_tmr   <= '0;
                        r_state <= ST_RUN;
                    end else if (r_tmr == TMR_W'(KS_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_tmr   <= '0;
                        r_state <= ST_NOKEY;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_key_hs) begin
                        r_key_pend <= s_key_tdata;
                        r_state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_zero) begin
                        r_ks_key <= r_key_pend;
                        r_tmr    <= '0;
                        r_state  <= ST_KS_RST;
                    end
                end
                default: begin
                    r_state <= ST_NOKEY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
